// File: rtl/cpu_pkg.sv
// Shared types and constants for the operand forwarding logic.
// Latency: n/a (declarations and one pure helper function).
// Backpressure: n/a.
//
// Contents: operand-mux select codes, register address width, the
// destination tag record tracked per pipeline stage, and the forwarding
// match helper used for both operands.
package cpu_pkg;

  localparam int REG_AW = 5;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 16;

  // Operand 3:1 mux select codes. Code 2'b11 is never produced.
  localparam logic [SEL_W-1:0] SEL_REGFILE = 2'b00;
  localparam logic [SEL_W-1:0] SEL_EXMEM   = 2'b01;
  localparam logic [SEL_W-1:0] SEL_MEMWB   = 2'b10;

  // Destination tag carried alongside an instruction as it moves EX->MEM->WB.
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic [REG_AW-1:0] dest;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

  localparam tag_t TAG_BUBBLE = '0;

  // True when the stage holding tag t will write the register the EX
  // instruction reads through this operand. r0 is hardwired zero, so a
  // write to it never counts as a producer.
  function automatic logic fwd_hit(input tag_t t, input logic [REG_AW-1:0] src,
                                   input logic uses);
    return t.valid & t.reg_write & (t.dest != '0) & (t.dest == src) & uses;
  endfunction

  // MEM holds the younger result, so it takes priority over WB.
  function automatic logic [SEL_W-1:0] fwd_select(input tag_t mem_t, input tag_t wb_t,
                                                  input logic [REG_AW-1:0] src,
                                                  input logic uses);
    if (fwd_hit(mem_t, src, uses)) begin
      return SEL_EXMEM;
    end
    if (fwd_hit(wb_t, src, uses)) begin
      return SEL_MEMWB;
    end
    return SEL_REGFILE;
  endfunction

endpackage

// File: rtl/fwd_tag_stage.sv
// One pipeline-stage destination tag register with bubble insertion.
// Latency: 1 cycle (tag_i captured on the rising edge when load_i=1).
// Backpressure: none; load_i=0 holds the tag, bubble_i loads an invalid tag.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset (tag -> invalid)
//   load_i       capture a new value this edge
//   bubble_i     capture an invalid tag instead of tag_i
//   tag_i        incoming tag from the previous stage
//   tag_o        registered tag of this stage
module fwd_tag_stage
  import cpu_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic bubble_i,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t tag_q;
  tag_t tag_d;

  always_comb begin
    tag_d = tag_q;
    if (load_i) begin
      tag_d = bubble_i ? TAG_BUBBLE : tag_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= TAG_BUBBLE;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign tag_o = tag_q;

endmodule

// File: rtl/forward_select_unit.sv
// Operand forwarding selects, load-use stall and stall-cycle counter.
// Latency: selects for an instruction accepted from ID at edge N appear in cycle N+1; stall is same-cycle combinational.
// Backpressure: stall holds PC and IF/ID and bubbles EX; flush overrides stall.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   idValid, idRs, idRt         instruction in ID and its source registers
//   idUsesRs, idUsesRt          source register read enables
//   idRegWrite, idMemRead, idRd destination write enable, load flag, dest reg
//   flush                       squash ID and EX (taken branch/jump)
//   fwdSelA, fwdSelB            operand mux selects for the instruction in EX
//   stall                       load-use hazard: hold front end, bubble EX
//   stallCount                  saturating count of stall cycles
module forward_select_unit #(
  parameter int REG_AW = cpu_pkg::REG_AW,
  parameter int SEL_W  = cpu_pkg::SEL_W,
  parameter int CNT_W  = cpu_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              idValid,
  input  logic [REG_AW-1:0] idRs,
  input  logic [REG_AW-1:0] idRt,
  input  logic              idUsesRs,
  input  logic              idUsesRt,
  input  logic              idRegWrite,
  input  logic              idMemRead,
  input  logic [REG_AW-1:0] idRd,
  input  logic              flush,
  output logic [SEL_W-1:0]  fwdSelA,
  output logic [SEL_W-1:0]  fwdSelB,
  output logic              stall,
  output logic [CNT_W-1:0]  stallCount
);

  import cpu_pkg::*;

  tag_t ex_tag_d;
  tag_t ex_tag_q;
  tag_t mem_tag_q;
  tag_t wb_tag_q;

  logic [REG_AW-1:0] ex_rs_q, ex_rs_d;
  logic [REG_AW-1:0] ex_rt_q, ex_rt_d;
  logic              ex_uses_rs_q, ex_uses_rs_d;
  logic              ex_uses_rt_q, ex_uses_rt_d;

  logic              stall_w;
  logic              bubble_ex;
  logic              load_in_ex;
  logic              rs_dep;
  logic              rt_dep;

  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  // ---------------------------------------------------------------------------
  // Load-use hazard: a load in EX whose destination is read by the ID
  // instruction. One bubble is enough because next cycle the load sits in
  // MEM and its data reaches the consumer through the MEM/WB path.
  // ---------------------------------------------------------------------------
  assign load_in_ex = ex_tag_q.valid & ex_tag_q.mem_read & ex_tag_q.reg_write
                    & (ex_tag_q.dest != '0);
  assign rs_dep     = idUsesRs & (idRs == ex_tag_q.dest);
  assign rt_dep     = idUsesRt & (idRt == ex_tag_q.dest);
  assign stall_w    = idValid & ~flush & load_in_ex & (rs_dep | rt_dep);
  assign stall      = stall_w;

  // Both a stall and a flush keep the ID instruction out of EX. The branch
  // being flushed is already in EX and moves on to MEM normally.
  assign bubble_ex  = stall_w | flush;

  assign ex_tag_d = '{valid:     idValid,
                      reg_write: idRegWrite,
                      mem_read:  idMemRead,
                      dest:      idRd};

  // ---------------------------------------------------------------------------
  // Shadow tag pipeline EX -> MEM -> WB
  // ---------------------------------------------------------------------------
  fwd_tag_stage u_ex_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (1'b1),
    .bubble_i (bubble_ex),
    .tag_i    (ex_tag_d),
    .tag_o    (ex_tag_q)
  );

  fwd_tag_stage u_mem_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (1'b1),
    .bubble_i (1'b0),
    .tag_i    (ex_tag_q),
    .tag_o    (mem_tag_q)
  );

  fwd_tag_stage u_wb_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (1'b1),
    .bubble_i (1'b0),
    .tag_i    (mem_tag_q),
    .tag_o    (wb_tag_q)
  );

  // ---------------------------------------------------------------------------
  // Source registers of the instruction in EX. Use bits are cleared for a
  // bubble so an empty EX slot never asks for a forwarded operand.
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_rs_d      = idRs;
    ex_rt_d      = idRt;
    ex_uses_rs_d = idUsesRs & idValid & ~bubble_ex;
    ex_uses_rt_d = idUsesRt & idValid & ~bubble_ex;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_uses_rs_q <= 1'b0;
      ex_uses_rt_q <= 1'b0;
    end else begin
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_uses_rs_q <= ex_uses_rs_d;
      ex_uses_rt_q <= ex_uses_rt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding selects: registered state only, no path from ID inputs.
  // A load in MEM could only match here if its consumer skipped the stall,
  // which the hazard logic above rules out.
  // ---------------------------------------------------------------------------
  assign fwdSelA = SEL_W'(fwd_select(mem_tag_q, wb_tag_q, ex_rs_q, ex_uses_rs_q));
  assign fwdSelB = SEL_W'(fwd_select(mem_tag_q, wb_tag_q, ex_rt_q, ex_uses_rt_q));

  // ---------------------------------------------------------------------------
  // Saturating stall-cycle counter
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_w && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stallCount = stall_cnt_q;

endmodule

// File: tb/tb_forward_select_unit.sv
// Self-checking bench for forward_select_unit: directed hazard cases, then
// random instruction streams compared against an instruction-level model.
// A second instance with a narrow counter exercises counter saturation.
module tb_forward_select_unit;

  localparam int SAT_W   = 6;
  localparam int SAT_MAX = (1 << SAT_W) - 1;
  localparam int CNT_MAX = 65535;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       idValid = 1'b0;
  logic [4:0] idRs = '0;
  logic [4:0] idRt = '0;
  logic       idUsesRs = 1'b0;
  logic       idUsesRt = 1'b0;
  logic       idRegWrite = 1'b0;
  logic       idMemRead = 1'b0;
  logic [4:0] idRd = '0;
  logic       flush = 1'b0;

  logic [1:0]       fwdSelA, fwdSelB, fwdSelA_s, fwdSelB_s;
  logic             stall, stall_s;
  logic [15:0]      stallCount;
  logic [SAT_W-1:0] stallCount_s;

  always #5 clk = ~clk;

  forward_select_unit dut (
    .clk(clk), .rst_n(rst_n), .idValid(idValid), .idRs(idRs), .idRt(idRt),
    .idUsesRs(idUsesRs), .idUsesRt(idUsesRt), .idRegWrite(idRegWrite),
    .idMemRead(idMemRead), .idRd(idRd), .flush(flush),
    .fwdSelA(fwdSelA), .fwdSelB(fwdSelB), .stall(stall), .stallCount(stallCount)
  );

  forward_select_unit #(.CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst_n(rst_n), .idValid(idValid), .idRs(idRs), .idRt(idRt),
    .idUsesRs(idUsesRs), .idUsesRt(idUsesRt), .idRegWrite(idRegWrite),
    .idMemRead(idMemRead), .idRd(idRd), .flush(flush),
    .fwdSelA(fwdSelA_s), .fwdSelB(fwdSelB_s), .stall(stall_s), .stallCount(stallCount_s)
  );

  // ---------------------------------------------------------------------------
  // Instruction-level reference model: the instructions sitting in EX, MEM, WB
  // ---------------------------------------------------------------------------
  typedef struct {
    bit v;
    bit wr;
    bit ld;
    int rd;
    int rs;
    int rt;
    bit urs;
    bit urt;
  } ins_t;

  ins_t m_ex, m_mem, m_wb;
  int   cnt16;
  int   cnt6;
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic ins_t nop();
    ins_t i;
    i = '{v: 0, wr: 0, ld: 0, rd: 0, rs: 0, rt: 0, urs: 0, urt: 0};
    return i;
  endfunction

  function automatic ins_t alu(int rd, int rs, int rt);
    ins_t i;
    i = '{v: 1, wr: 1, ld: 0, rd: rd, rs: rs, rt: rt, urs: 1, urt: 1};
    return i;
  endfunction

  function automatic ins_t lw(int rd, int rs);
    ins_t i;
    i = '{v: 1, wr: 1, ld: 1, rd: rd, rs: rs, rt: 0, urs: 1, urt: 0};
    return i;
  endfunction

  // Which older instruction supplies the operand the EX instruction reads.
  function automatic int exp_sel(int src, bit used);
    if (!m_ex.v || !used) return 0;
    if (m_mem.v && m_mem.wr && m_mem.rd != 0 && m_mem.rd == src) return 1;
    if (m_wb.v && m_wb.wr && m_wb.rd != 0 && m_wb.rd == src) return 2;
    return 0;
  endfunction

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_ex  = nop();
    m_mem = nop();
    m_wb  = nop();
    cnt16 = 0;
    cnt6  = 0;
  endtask

  // One clock cycle: present instruction i in ID, check all outputs against
  // the model, then advance the model for the coming rising edge.
  task automatic step(input ins_t i, input bit fl);
    bit st;
    int ea, eb;
    @(negedge clk);
    idValid    = i.v;
    idRegWrite = i.wr;
    idMemRead  = i.ld;
    idRd       = 5'(i.rd);
    idRs       = 5'(i.rs);
    idRt       = 5'(i.rt);
    idUsesRs   = i.urs;
    idUsesRt   = i.urt;
    flush      = fl;
    #1;
    st = i.v && !fl && m_ex.v && m_ex.ld && m_ex.wr && m_ex.rd != 0 &&
         ((i.urs && i.rs == m_ex.rd) || (i.urt && i.rt == m_ex.rd));
    ea = exp_sel(m_ex.rs, m_ex.urs);
    eb = exp_sel(m_ex.rt, m_ex.urt);
    check_eq("stall", stall, st);
    check_eq("fwdSelA", fwdSelA, ea);
    check_eq("fwdSelB", fwdSelB, eb);
    check_eq("stallCount", stallCount, cnt16);
    check_eq("sat_stall", stall_s, st);
    check_eq("sat_fwdSelA", fwdSelA_s, ea);
    check_eq("sat_fwdSelB", fwdSelB_s, eb);
    check_eq("sat_stallCount", stallCount_s, cnt6);
    if (st) begin
      if (cnt16 < CNT_MAX) cnt16++;
      if (cnt6 < SAT_MAX) cnt6++;
    end
    m_wb  = m_mem;
    m_mem = m_ex;
    m_ex  = (st || fl || !i.v) ? nop() : i;
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_stall", stall, 0);
    check_eq("rst_fwdSelA", fwdSelA, 0);
    check_eq("rst_fwdSelB", fwdSelB, 0);
    check_eq("rst_stallCount", stallCount, 0);
    check_eq("rst_sat_stallCount", stallCount_s, 0);
    model_clear();
    idValid = 1'b0;
    flush   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    ins_t r;
    bit   fl;
    model_clear();
    #3;
    do_reset();

    // Back-to-back RAW: add r3 ; add r4,r3,r1 -> EX/MEM forward on A.
    step(alu(3, 1, 2), 0);
    step(alu(4, 3, 1), 0);
    step(nop(), 0);
    check_eq("raw1_selA", fwdSelA, 1);
    check_eq("raw1_selB", fwdSelB, 0);

    // Distance two: add r3 ; nop ; add r5,r3,r3 -> MEM/WB forward on both.
    step(alu(3, 1, 2), 0);
    step(nop(), 0);
    step(alu(5, 3, 3), 0);
    step(nop(), 0);
    check_eq("raw2_selA", fwdSelA, 2);
    check_eq("raw2_selB", fwdSelB, 2);

    // Two producers of r3: the younger one (MEM) wins.
    step(alu(3, 1, 2), 0);
    step(alu(3, 2, 2), 0);
    step(alu(6, 3, 2), 0);
    step(nop(), 0);
    check_eq("prio_selA", fwdSelA, 1);
    check_eq("prio_selB", fwdSelB, 0);

    // Load-use: one stall cycle, then MEM/WB forwarding on both operands.
    do_reset();
    step(lw(2, 1), 0);
    step(alu(4, 2, 2), 0);
    check_eq("lu_stall", stall, 1);
    step(alu(4, 2, 2), 0);
    check_eq("lu_stall_drop", stall, 0);
    check_eq("lu_count", stallCount, 1);
    step(nop(), 0);
    check_eq("lu_selA", fwdSelA, 2);
    check_eq("lu_selB", fwdSelB, 2);

    // Writes to r0 never forward and never stall.
    step(alu(0, 1, 1), 0);
    step(alu(4, 0, 0), 0);
    step(nop(), 0);
    check_eq("r0_selA", fwdSelA, 0);
    check_eq("r0_selB", fwdSelB, 0);
    step(lw(0, 1), 0);
    step(alu(5, 0, 0), 0);
    check_eq("r0_lu_stall", stall, 0);

    // Flush in the same cycle as a load-use hazard: flush wins.
    step(lw(2, 1), 0);
    step(alu(4, 2, 2), 1);
    check_eq("flush_stall", stall, 0);
    step(nop(), 0);
    check_eq("flush_count", stallCount, 1);
    check_eq("flush_selA", fwdSelA, 0);

    // Random traffic with a small register pool to provoke many hazards.
    for (int n = 0; n < 3000; n++) begin
      r.v   = ($urandom_range(0, 99) < 85);
      r.wr  = ($urandom_range(0, 99) < 80);
      r.ld  = r.wr && ($urandom_range(0, 99) < 35);
      r.rd  = $urandom_range(0, 3);
      r.rs  = $urandom_range(0, 3);
      r.rt  = $urandom_range(0, 3);
      r.urs = $urandom_range(0, 1);
      r.urt = $urandom_range(0, 1);
      fl    = ($urandom_range(0, 7) == 0);
      step(r, fl);
    end

    // Drive repeated load-use pairs until the narrow counter saturates.
    for (int n = 0; n < SAT_MAX + 10; n++) begin
      step(lw(2, 1), 0);
      step(alu(4, 2, 2), 0);
    end
    step(nop(), 0);
    check_eq("sat_hold", stallCount_s, SAT_MAX);

    // Reset while a stall is being raised.
    step(lw(2, 1), 0);
    step(alu(4, 2, 2), 0);
    check_eq("mid_stall", stall, 1);
    do_reset();
    step(alu(4, 2, 2), 0);
    check_eq("post_rst_stall", stall, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout reached without completion");
    $fatal(1, "timeout");
  end

endmodule
